// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: generic width/polynomial, sop/eop packet framing,
// partial last beat, valid/ready handshake and optional expected-CRC compare.
module crc_stream_engine #(
    parameter int          DW     = 32,
    parameter int          CW     = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'h00000000,
    parameter int          NBW    = $clog2(DW/8) + 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_vld,
    output logic           o_rdy,
    input  logic           i_sop,
    input  logic           i_eop,
    input  logic [DW-1:0]  i_d,
    input  logic [NBW-1:0] i_nbytes,
    input  logic           i_exp_chk,
    input  logic [CW-1:0]  i_exp_crc,
    output logic [CW-1:0]  o_crc,
    output logic           o_res_vld,
    output logic [CW-1:0]  o_res_crc,
    output logic           o_res_ok,
    output logic [15:0]    o_byte_cnt,
    output logic           o_err_proto
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  crc_q;
    logic [15:0]    cnt_q;
    logic           err_q;
    logic [CW-1:0]  res_crc_q;
    logic           res_ok_q;
    logic [15:0]    res_cnt_q;

    logic           acc;
    logic           nb_bad;
    logic [NBW-1:0] eff_nb;
    logic [CW-1:0]  crc_seed;
    logic [CW-1:0]  crc_nxt;
    logic [CW-1:0]  res_nxt;
    logic [15:0]    cnt_base;
    logic [16:0]    cnt_sum;
    logic [15:0]    cnt_nxt;

    // Bit-serial MSB-first LFSR, unrolled over the first nbits of the beat.
    function automatic logic [CW-1:0] crc_beat(input logic [CW-1:0] seed,
                                               input logic [DW-1:0] d,
                                               input int nbits);
        logic [CW-1:0] c;
        logic          fb;
        c = seed;
        for (int i = 0; i < DW; i++) begin
            if (i < nbits) begin
                fb = c[CW-1] ^ d[DW-1-i];
                c  = {c[CW-2:0], 1'b0} ^ (fb ? POLY[CW-1:0] : '0);
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    assign o_rdy  = (state != DONE);
    assign acc    = i_vld && o_rdy;
    assign nb_bad = i_eop && ((i_nbytes == '0) || (int'(i_nbytes) > DW/8));
    assign eff_nb = (i_eop && !nb_bad) ? i_nbytes : NBW'(DW/8);

    assign crc_seed = i_sop ? INIT[CW-1:0] : crc_q;
    assign crc_nxt  = crc_beat(crc_seed, i_d, int'(eff_nb) * 8);
    assign res_nxt  = crc_nxt ^ XOROUT[CW-1:0];
    assign cnt_base = i_sop ? 16'h0000 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + {{(17-NBW){1'b0}}, eff_nb};
    assign cnt_nxt  = sat16(cnt_sum);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            crc_q     <= INIT[CW-1:0];
            cnt_q     <= 16'h0000;
            err_q     <= 1'b0;
            res_crc_q <= '0;
            res_ok_q  <= 1'b0;
            res_cnt_q <= 16'h0000;
        end else begin
            err_q <= 1'b0;
            if (i_clr) begin
                state <= IDLE;
                crc_q <= INIT[CW-1:0];
                cnt_q <= 16'h0000;
            end else begin
                if (state == DONE)
                    state <= IDLE;
                if (acc) begin
                    if (!i_sop && state == IDLE) begin
                        err_q <= 1'b1;
                    end else begin
                        crc_q <= crc_nxt;
                        cnt_q <= cnt_nxt;
                        err_q <= (i_sop && state == BUSY) || nb_bad;
                        // Results land with the eop so they are visible during DONE.
                        if (i_eop) begin
                            state     <= DONE;
                            res_crc_q <= res_nxt;
                            res_ok_q  <= !i_exp_chk || (res_nxt == i_exp_crc);
                            res_cnt_q <= cnt_nxt;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
            end
        end
    end

    // A clear during DONE suppresses the strobe; held results stay.
    assign o_res_vld   = (state == DONE) && !i_clr;
    assign o_crc       = crc_q;
    assign o_res_crc   = res_crc_q;
    assign o_res_ok    = res_ok_q;
    assign o_byte_cnt  = res_cnt_q;
    assign o_err_proto = err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: 32-bit CRC-32/MPEG-2 (raw and inverted
// output) instances driven by a vector table, plus a 64-bit CRC-16 instance.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        clr, vld, sop, eop, chk;
    logic [31:0] d, ecrc;
    logic [2:0]  nb;

    logic        rdy_a, rv_a, ok_a, err_a;
    logic [31:0] crc_a, res_a;
    logic [15:0] cnt_a;
    logic        rdy_b, rv_b, ok_b, err_b;
    logic [31:0] crc_b, res_b;
    logic [15:0] cnt_b;

    logic        vld64, sop64, eop64, chk64;
    logic [63:0] d64;
    logic [3:0]  nb64;
    logic [15:0] ecrc64;
    logic        rdy_c, rv_c, ok_c, err_c;
    logic [15:0] crc_c, res_c, cnt_c;

    crc_stream_engine u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_vld(vld), .o_rdy(rdy_a),
        .i_sop(sop), .i_eop(eop), .i_d(d), .i_nbytes(nb), .i_exp_chk(chk),
        .i_exp_crc(ecrc), .o_crc(crc_a), .o_res_vld(rv_a), .o_res_crc(res_a),
        .o_res_ok(ok_a), .o_byte_cnt(cnt_a), .o_err_proto(err_a)
    );

    crc_stream_engine #(.XOROUT(32'hFFFFFFFF)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_vld(vld), .o_rdy(rdy_b),
        .i_sop(sop), .i_eop(eop), .i_d(d), .i_nbytes(nb), .i_exp_chk(chk),
        .i_exp_crc(ecrc), .o_crc(crc_b), .o_res_vld(rv_b), .o_res_crc(res_b),
        .o_res_ok(ok_b), .o_byte_cnt(cnt_b), .o_err_proto(err_b)
    );

    crc_stream_engine #(.DW(64), .CW(16), .POLY(32'h00001021), .INIT(32'h0000FFFF)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_vld(vld64), .o_rdy(rdy_c),
        .i_sop(sop64), .i_eop(eop64), .i_d(d64), .i_nbytes(nb64), .i_exp_chk(chk64),
        .i_exp_crc(ecrc64), .o_crc(crc_c), .o_res_vld(rv_c), .o_res_crc(res_c),
        .o_res_ok(ok_c), .o_byte_cnt(cnt_c), .o_err_proto(err_c)
    );

    typedef struct {
        logic        vld, sop, eop, clr;
        logic [31:0] d;
        logic [2:0]  nb;
        logic        chk;
        logic [31:0] ecrc;
        logic        e_rdy, e_rv, e_err;
        logic        cmp_res;
        logic [31:0] e_res, e_resx;
        logic        e_ok, e_okx;
        logic [15:0] e_cnt;
        logic        cmp_raw;
        logic [31:0] e_raw;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-at-a-time reference CRC (non-reflected), result in the low cw bits.
    function automatic logic [31:0] ref_crc(input logic [7:0] m[16], input int n,
                                            input int cw, input logic [31:0] poly,
                                            input logic [31:0] init);
        logic [31:0] c, mask;
        mask = (cw == 32) ? 32'hFFFFFFFF : ((32'h1 << cw) - 32'h1);
        c = init & mask;
        for (int b = 0; b < n; b++) begin
            c = c ^ ({24'h0, m[b]} << (cw - 8));
            for (int k = 0; k < 8; k++) begin
                if (c[cw-1]) c = ((c << 1) ^ poly) & mask;
                else         c = (c << 1) & mask;
            end
        end
        return c;
    endfunction

    function automatic vec_t bt(input logic v, input logic s, input logic e, input logic c,
                                input logic [31:0] dd, input logic [2:0] n, input logic ck,
                                input logic [31:0] ec, input logic r, input logic rv,
                                input logic er);
        vec_t t;
        t.vld = v; t.sop = s; t.eop = e; t.clr = c; t.d = dd; t.nb = n;
        t.chk = ck; t.ecrc = ec; t.e_rdy = r; t.e_rv = rv; t.e_err = er;
        t.cmp_res = 1'b0; t.e_res = '0; t.e_resx = '0; t.e_ok = 1'b0; t.e_okx = 1'b0;
        t.e_cnt = '0; t.cmp_raw = 1'b0; t.e_raw = '0;
        return t;
    endfunction

    task automatic set_res(input logic [31:0] r, input logic [31:0] rx, input logic ok,
                           input logic okx, input logic [15:0] cnt);
        int k;
        k = tv.size() - 1;
        tv[k].cmp_res = 1'b1; tv[k].e_res = r; tv[k].e_resx = rx;
        tv[k].e_ok = ok; tv[k].e_okx = okx; tv[k].e_cnt = cnt;
    endtask

    task automatic set_raw(input logic [31:0] r);
        tv[tv.size()-1].cmp_raw = 1'b1;
        tv[tv.size()-1].e_raw = r;
    endtask

    task automatic idle_inputs();
        vld = 1'b0; sop = 1'b0; eop = 1'b0; clr = 1'b0; chk = 1'b0;
        vld64 = 1'b0; sop64 = 1'b0; eop64 = 1'b0; chk64 = 1'b0;
    endtask

    logic [7:0]  msg[16];
    logic [31:0] r1234, r16;
    logic [3:0]  badnb[2];

    initial begin
        idle_inputs();
        d = '0; nb = '0; ecrc = '0; d64 = '0; nb64 = '0; ecrc64 = '0;
        rst_n = 1'b0;
        #12;
        check1("rst_rdy", rdy_a, 1'b1);
        check1("rst_res_vld", rv_a, 1'b0);
        check32("rst_res_crc", res_a, 32'h0);
        check1("rst_ok", ok_a, 1'b0);
        check32("rst_cnt", {16'h0, cnt_a}, 32'h0);
        check1("rst_err", err_a, 1'b0);
        check32("rst_crc", crc_a, 32'hFFFFFFFF);
        check32("rst_crc16", {16'h0, crc_c}, 32'h0000FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) msg[i] = 8'h00;
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34;
        r1234 = ref_crc(msg, 4, 32, 32'h04C11DB7, 32'hFFFFFFFF);

        // vld sop eop clr data nb chk exp_crc | rdy res_vld err
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,0,32'h39000000,1,0,0, 1,1,0));
        set_res(32'h0376E6E7, 32'hFC891918, 1, 1, 16'd9);
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 0,0,0));
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,0,32'h39ABCDEF,1,1,32'hFC891918, 1,1,0));
        set_res(32'h0376E6E7, 32'hFC891918, 0, 1, 16'd9);
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 0,0,0));
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,0,32'h39000000,1,1,32'hFC891919, 1,1,0));
        set_res(32'h0376E6E7, 32'hFC891918, 0, 0, 16'd9);
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 0,0,0));
        // single-beat packet, then the next sop held through DONE
        tv.push_back(bt(1,1,1,0,32'h31323334,4,0,0, 1,1,0));
        set_res(r1234, ~r1234, 1, 1, 16'd4);
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 0,0,0));
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,0,32'h39000000,1,0,0, 1,1,0));
        set_res(32'h0376E6E7, 32'hFC891918, 1, 1, 16'd9);
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 0,0,0));
        // sop in the middle of a packet restarts it
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,1));
        tv.push_back(bt(1,0,0,0,32'h35363738,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,0,32'h39000000,1,0,0, 1,1,0));
        set_res(32'h0376E6E7, 32'hFC891918, 1, 1, 16'd9);
        set_raw(32'h0376E6E7);
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 0,0,0));
        // beat without sop in IDLE, then clear mid-packet
        tv.push_back(bt(1,0,0,0,32'h12345678,0,0,0, 1,0,1));
        set_raw(32'h0376E6E7);
        tv.push_back(bt(1,1,0,0,32'h31323334,0,0,0, 1,0,0));
        tv.push_back(bt(1,0,1,1,32'h35363738,1,0,0, 1,0,0));
        set_raw(32'hFFFFFFFF);
        tv.push_back(bt(1,0,1,0,32'h39000000,1,0,0, 1,0,1));
        tv.push_back(bt(0,0,0,0,32'h0,0,0,0, 1,0,0));
        set_res(32'h0376E6E7, 32'hFC891918, 1, 1, 16'd9);
        set_raw(32'hFFFFFFFF);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            check1($sformatf("v%0d_rdy", i), rdy_a, tv[i].e_rdy);
            check1($sformatf("v%0d_rdy_x", i), rdy_b, tv[i].e_rdy);
            vld = tv[i].vld; sop = tv[i].sop; eop = tv[i].eop; clr = tv[i].clr;
            d = tv[i].d; nb = tv[i].nb; chk = tv[i].chk; ecrc = tv[i].ecrc;
            @(posedge clk);
            #1;
            idle_inputs();
            check1($sformatf("v%0d_res_vld", i), rv_a, tv[i].e_rv);
            check1($sformatf("v%0d_res_vld_x", i), rv_b, tv[i].e_rv);
            check1($sformatf("v%0d_err", i), err_a, tv[i].e_err);
            check1($sformatf("v%0d_err_x", i), err_b, tv[i].e_err);
            if (tv[i].cmp_res) begin
                check32($sformatf("v%0d_res_crc", i), res_a, tv[i].e_res);
                check32($sformatf("v%0d_res_crc_x", i), res_b, tv[i].e_resx);
                check1($sformatf("v%0d_ok", i), ok_a, tv[i].e_ok);
                check1($sformatf("v%0d_ok_x", i), ok_b, tv[i].e_okx);
                check32($sformatf("v%0d_cnt", i), {16'h0, cnt_a}, {16'h0, tv[i].e_cnt});
                check32($sformatf("v%0d_cnt_x", i), {16'h0, cnt_b}, {16'h0, tv[i].e_cnt});
            end
            if (tv[i].cmp_raw) begin
                check32($sformatf("v%0d_raw", i), crc_a, tv[i].e_raw);
                check32($sformatf("v%0d_raw_x", i), crc_b, tv[i].e_raw);
            end
        end

        // clear during DONE withdraws the strobe but keeps the held result
        @(negedge clk);
        vld = 1; sop = 1; eop = 1; d = 32'h31323334; nb = 3'd4;
        @(posedge clk); #1; idle_inputs();
        check1("done_res_vld", rv_a, 1'b1);
        clr = 1'b1;
        #1;
        check1("clr_done_res_vld", rv_a, 1'b0);
        @(posedge clk); #1; idle_inputs();
        check1("clr_done_rdy", rdy_a, 1'b1);
        check32("clr_done_crc", crc_a, 32'hFFFFFFFF);
        check32("clr_done_held", res_a, r1234);

        // async reset during DONE (bad nbytes so the error strobe is live too)
        @(negedge clk);
        vld = 1; sop = 1; eop = 1; d = 32'h31323334; nb = 3'd0;
        @(posedge clk); #1; idle_inputs();
        check1("pre_rst_res_vld", rv_a, 1'b1);
        check1("pre_rst_err", err_a, 1'b1);
        check32("pre_rst_cnt", {16'h0, cnt_a}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check1("arst_rdy", rdy_a, 1'b1);
        check1("arst_res_vld", rv_a, 1'b0);
        check32("arst_res_crc", res_a, 32'h0);
        check1("arst_ok", ok_a, 1'b0);
        check32("arst_cnt", {16'h0, cnt_a}, 32'h0);
        check1("arst_err", err_a, 1'b0);
        check32("arst_crc", crc_a, 32'hFFFFFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // CRC-16/CCITT-FALSE on the 64-bit instance
        @(negedge clk);
        vld64 = 1; sop64 = 1; d64 = 64'h3132333435363738;
        @(posedge clk); #1; idle_inputs();
        check1("c16_first_rv", rv_c, 1'b0);
        @(negedge clk);
        vld64 = 1; eop64 = 1; nb64 = 4'd1; d64 = 64'h3911223344556677;
        @(posedge clk); #1; idle_inputs();
        check1("c16_rv", rv_c, 1'b1);
        check32("c16_res", {16'h0, res_c}, 32'h000029B1);
        check32("c16_cnt", {16'h0, cnt_c}, 32'd9);
        check1("c16_ok", ok_c, 1'b1);
        check1("c16_err", err_c, 1'b0);
        @(negedge clk);
        check1("c16_done_rdy", rdy_c, 1'b0);

        for (int i = 0; i < 16; i++) msg[i] = 8'h00;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        r16 = ref_crc(msg, 16, 16, 32'h00001021, 32'h0000FFFF);
        badnb[0] = 4'd0; badnb[1] = 4'd9;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            vld64 = 1; sop64 = 1; d64 = 64'h3132333435363738;
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
            vld64 = 1; eop64 = 1; nb64 = badnb[j]; d64 = 64'h3900000000000000;
            @(posedge clk); #1; idle_inputs();
            check1($sformatf("c16_bad%0d_rv", j), rv_c, 1'b1);
            check1($sformatf("c16_bad%0d_err", j), err_c, 1'b1);
            check32($sformatf("c16_bad%0d_res", j), {16'h0, res_c}, r16);
            check32($sformatf("c16_bad%0d_cnt", j), {16'h0, cnt_c}, 32'd16);
            @(negedge clk);
        end

        // 8192 full 8-byte beats reach 65536 bytes: counter must saturate
        for (int i = 0; i < 8192; i++) begin
            @(negedge clk);
            vld64 = 1; sop64 = (i == 0); eop64 = (i == 8191); nb64 = 4'd8; d64 = 64'h0;
        end
        @(posedge clk); #1; idle_inputs();
        check1("sat_rv", rv_c, 1'b1);
        check32("sat_cnt", {16'h0, cnt_c}, 32'h0000FFFF);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
